// File: rtl/core_instr_issuer_if.sv
// Host/ROM/core-facing signal bundle for core_instr_issuer.
// The master side is the host plus program ROM; the slave side is the issuer.
interface core_instr_issuer_if #(
  parameter int unsigned INSTRUCTION_WIDTH = 15,
  parameter int unsigned PC_WIDTH          = 8
);
  logic                         start;
  logic [PC_WIDTH-1:0]          prog_len;
  logic                         stall;
  logic [PC_WIDTH-1:0]          rom_addr;
  logic [INSTRUCTION_WIDTH-1:0] rom_data;
  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic                         issue_valid;
  logic [PC_WIDTH-1:0]          pc;
  logic                         busy;
  logic                         done;

  modport master (
    output start, prog_len, stall, rom_data,
    input  rom_addr, instruction, issue_valid, pc, busy, done
  );

  modport slave (
    input  start, prog_len, stall, rom_data,
    output rom_addr, instruction, issue_valid, pc, busy, done
  );
endinterface

// File: rtl/core_instr_issuer.sv
// Issues prog_len words from a synchronous program ROM to the core's instruction
// port, each held HOLD_CYCLES clocks, parking the port on NOP_INSTR otherwise.
module core_instr_issuer #(
  parameter int unsigned                  INSTRUCTION_WIDTH = 15,
  parameter int unsigned                  PC_WIDTH          = 8,
  parameter int unsigned                  HOLD_CYCLES       = 2,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR         = 15'h42C0
) (
  input logic               clk,
  input logic               reset,
  core_instr_issuer_if.slave bus
);

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_DRAIN
  } state_e;

  state_e                       state_q;
  logic [PC_WIDTH-1:0]          pc_q;
  logic [PC_WIDTH-1:0]          len_q;
  logic [HW-1:0]                hold_q;
  logic [INSTRUCTION_WIDTH-1:0] instr_q;
  logic                         valid_q;
  logic                         busy_q;
  logic                         done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      hold_q  <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bus.prog_len != '0) begin
              len_q   <= bus.prog_len;
              pc_q    <= '0;
              state_q <= S_FETCH;
            end else begin
              // Empty program: report completion without touching pc/len.
              done_q  <= 1'b1;
              state_q <= S_DRAIN;
            end
          end
        end
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          instr_q <= bus.rom_data;
          valid_q <= 1'b1;
          hold_q  <= '0;
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!bus.stall) begin
            if (hold_q == HOLD_LAST) begin
              instr_q <= NOP_INSTR;
              valid_q <= 1'b0;
              if (pc_q == len_q - PC_WIDTH'(1)) begin
                done_q  <= 1'b1;
                state_q <= S_DRAIN;
              end else begin
                pc_q    <= pc_q + PC_WIDTH'(1);
                state_q <= S_FETCH;
              end
            end else begin
              hold_q <= hold_q + HW'(1);
            end
          end
        end
        S_DRAIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rom_addr    = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instruction = instr_q;
  assign bus.issue_valid = valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_core_instr_issuer.sv
// Directed cycle-by-cycle bench for core_instr_issuer with a synchronous ROM model.
module tb_core_instr_issuer;

  localparam logic [14:0] NOP = 15'h42C0;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [14:0] rom [256];

  core_instr_issuer_if bus ();

  core_instr_issuer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  // Snapshot order: {issue_valid, instruction, busy, done, pc}
  logic [25:0] obs;
  assign obs = {bus.issue_valid, bus.instruction, bus.busy, bus.done, bus.pc};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b1;
    bus.prog_len = 8'd5;
    bus.stall = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (obs !== {1'b0, NOP, 1'b0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_state got=%h want=%h", obs, {1'b0, NOP, 1'b0, 1'b0, 8'd0});
    end
    reset = 1'b0;
    bus.start = 1'b0;
    tick();
    n_cmp++;
    if (obs !== {1'b0, NOP, 1'b0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_release_idle got=%h want=%h", obs, {1'b0, NOP, 1'b0, 1'b0, 8'd0});
    end
  endtask

  task automatic test_basic_run();
    logic [14:0] words [3];
    logic        v;
    logic [14:0] ins;
    logic [7:0]  p;
    words[0] = 15'h2800;
    words[1] = 15'h0290;
    words[2] = 15'h1648;
    rom[0] = words[0];
    rom[1] = words[1];
    rom[2] = words[2];
    bus.prog_len = 8'd3;
    bus.start = 1'b1;
    for (int e = 0; e < 14; e++) begin
      tick();
      if (e == 0) bus.start = 1'b0;
      v   = (e == 2 || e == 3 || e == 6 || e == 7 || e == 10 || e == 11);
      ins = v ? words[(e - 2) / 4] : NOP;
      p   = (e < 4) ? 8'd0 : (e < 8) ? 8'd1 : 8'd2;
      n_cmp++;
      if (obs !== {v, ins, (e <= 12), (e == 12), p}) begin
        n_fail++;
        $display("FAIL basic_run cycle=%0d got=%h want=%h", e, obs,
                 {v, ins, (e <= 12), (e == 12), p});
      end
    end
  endtask

  task automatic test_stall();
    logic v;
    rom[0] = 15'h5AD9;
    bus.prog_len = 8'd1;
    bus.start = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (e == 0) begin
        bus.start = 1'b0;
        bus.stall = 1'b1;
      end
      if (e == 1) bus.stall = 1'b0;
      if (e == 2) bus.stall = 1'b1;
      if (e == 5) bus.stall = 1'b0;
      v = (e >= 2 && e <= 6);
      n_cmp++;
      if (obs !== {v, v ? 15'h5AD9 : NOP, (e <= 7), (e == 7), 8'd0}) begin
        n_fail++;
        $display("FAIL stall cycle=%0d got=%h want=%h", e, obs,
                 {v, v ? 15'h5AD9 : NOP, (e <= 7), (e == 7), 8'd0});
      end
    end
  endtask

  task automatic test_zero_length();
    bus.prog_len = 8'd0;
    bus.start = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      if (e == 0) bus.start = 1'b0;
      n_cmp++;
      if (obs !== {1'b0, NOP, (e == 0), (e == 0), 8'd0}) begin
        n_fail++;
        $display("FAIL zero_length cycle=%0d got=%h want=%h", e, obs,
                 {1'b0, NOP, (e == 0), (e == 0), 8'd0});
      end
    end
  endtask

  task automatic test_start_while_busy();
    int   words_seen = 0;
    int   dones = 0;
    logic prev_v = 1'b0;
    rom[0] = 15'h2800;
    rom[1] = 15'h0290;
    bus.prog_len = 8'd2;
    bus.start = 1'b1;
    for (int e = 0; e < 16; e++) begin
      tick();
      if (e == 0) bus.start = 1'b0;
      if (e == 3) begin
        bus.start = 1'b1;
        bus.prog_len = 8'd7;
      end
      if (e == 4) bus.start = 1'b0;
      if (bus.issue_valid && !prev_v) words_seen++;
      if (bus.done) dones++;
      prev_v = bus.issue_valid;
    end
    n_cmp++;
    if (words_seen !== 2) begin
      n_fail++;
      $display("FAIL busy_start_words got=%0d want=2", words_seen);
    end
    n_cmp++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL busy_start_done_pulses got=%0d want=1", dones);
    end
    n_cmp++;
    if (obs !== {1'b0, NOP, 1'b0, 1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL busy_start_final got=%h want=%h", obs, {1'b0, NOP, 1'b0, 1'b0, 8'd1});
    end
  endtask

  task automatic test_reset_mid_issue();
    int dones = 0;
    rom[0] = 15'h2800;
    bus.prog_len = 8'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (obs !== {1'b1, 15'h2800, 1'b1, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL mid_reset_pre got=%h want=%h", obs, {1'b1, 15'h2800, 1'b1, 1'b0, 8'd0});
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (obs !== {1'b0, NOP, 1'b0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL mid_reset_post got=%h want=%h", obs, {1'b0, NOP, 1'b0, 1'b0, 8'd0});
    end
    for (int e = 0; e < 8; e++) begin
      tick();
      if (bus.done || bus.busy || bus.issue_valid) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_quiet active_cycles got=%0d want=0", dones);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 15'h7FFF;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.prog_len = '0;
    bus.stall = 1'b0;
    test_reset();
    test_basic_run();
    test_stall();
    test_zero_length();
    test_start_while_busy();
    test_reset_mid_issue();
    test_basic_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
